// File: rtl/timer_share_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : timer_share_arb_pkg
//  Description : Shared types and defaults for the shared-delay-timer arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package timer_share_arb_pkg;

   // Default geometry
   localparam int NUM_REQ_DEFAULT = 4;
   localparam int CNT_W_DEFAULT   = 20;

   // Arbiter state encodings
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      RUN  = ST_RUN,
      DONE = ST_DONE
   } state_e;

endpackage
`default_nettype wire

// File: rtl/timer_share_arb_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : timer_share_arb_rr_pick
//  Description : Combinational round-robin search: first set request bit at
//                or above rr_ptr, wrapping modulo NUM_REQ.
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_share_arb_rr_pick
   import timer_share_arb_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEFAULT,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [IDX_W-1:0]   winner,
   output logic               any_req
);

   int idx;

   // Scan from the farthest offset back to rr_ptr so the nearest set bit wins
   always_comb begin
      winner  = '0;
      any_req = 1'b0;
      idx     = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         if (req[idx]) begin
            winner  = IDX_W'(idx);
            any_req = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/timer_share_arb.sv
`default_nettype none
// ============================================================================
//  Module      : timer_share_arb
//  Description : Round-robin owner of one shared up-counter. Latches the
//                winner's delay, clears and runs the counter, and returns a
//                one-cycle done pulse when the counter reaches the delay.
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_share_arb
   import timer_share_arb_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEFAULT,
   parameter int CNT_W   = CNT_W_DEFAULT
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*CNT_W-1:0] delay,
   output logic [NUM_REQ-1:0]       grant,
   output logic [NUM_REQ-1:0]       done,
   output logic                     busy,
   output logic                     cnt_sclr,
   input  logic [CNT_W-1:0]         cnt_q
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_e             state_q,    state_d;
   logic [NUM_REQ-1:0] grant_q,    grant_d;
   logic [NUM_REQ-1:0] done_q,     done_d;
   logic               busy_q,     busy_d;
   logic               cnt_sclr_q, cnt_sclr_d;
   logic [IDX_W-1:0]   rr_ptr_q,   rr_ptr_d;
   logic [IDX_W-1:0]   owner_q,    owner_d;
   logic [CNT_W-1:0]   dly_q,      dly_d;

   logic [IDX_W-1:0]   w_winner;
   logic               w_any_req;

   timer_share_arb_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .req     (req),
      .rr_ptr  (rr_ptr_q),
      .winner  (w_winner),
      .any_req (w_any_req)
   );

   // Requester index following the owner, wrapping for non-power-of-two counts
   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
      if (int'(i) >= NUM_REQ - 1) begin
         return '0;
      end
      return i + IDX_W'(1);
   endfunction

   // Next-state and next-output decode; all outputs leave the block registered
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      done_d     = '0;
      busy_d     = busy_q;
      cnt_sclr_d = cnt_sclr_q;
      rr_ptr_d   = rr_ptr_q;
      owner_d    = owner_q;
      dly_d      = dly_q;
      case (state_q)
         IDLE: begin
            grant_d    = '0;
            busy_d     = 1'b0;
            cnt_sclr_d = 1'b1;
            if (w_any_req) begin
               state_d           = RUN;
               grant_d[w_winner] = 1'b1;
               owner_d           = w_winner;
               dly_d             = delay[int'(w_winner)*CNT_W +: CNT_W];
               busy_d            = 1'b1;
               cnt_sclr_d        = 1'b0;
            end
         end
         RUN: begin
            // An abort wins over a simultaneous expiry
            if (!req[owner_q]) begin
               state_d    = IDLE;
               grant_d    = '0;
               busy_d     = 1'b0;
               cnt_sclr_d = 1'b1;
               rr_ptr_d   = next_idx(owner_q);
            end else if (cnt_q == dly_q) begin
               state_d    = DONE;
               done_d     = grant_q;
               cnt_sclr_d = 1'b1;
            end
         end
         DONE: begin
            state_d    = IDLE;
            grant_d    = '0;
            busy_d     = 1'b0;
            cnt_sclr_d = 1'b1;
            rr_ptr_d   = next_idx(owner_q);
         end
         default: begin
            state_d    = IDLE;
            grant_d    = '0;
            busy_d     = 1'b0;
            cnt_sclr_d = 1'b1;
         end
      endcase
   end

   // State and output registers; reset holds the counter cleared
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         done_q     <= '0;
         busy_q     <= 1'b0;
         cnt_sclr_q <= 1'b1;
         rr_ptr_q   <= '0;
         owner_q    <= '0;
         dly_q      <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
         cnt_sclr_q <= cnt_sclr_d;
         rr_ptr_q   <= rr_ptr_d;
         owner_q    <= owner_d;
         dly_q      <= dly_d;
      end
   end

   assign grant    = grant_q;
   assign done     = done_q;
   assign busy     = busy_q;
   assign cnt_sclr = cnt_sclr_q;

endmodule
`default_nettype wire
